// File: rtl/alu_issue_pkg.sv
// Shared widths, ALU op codes, EX-register payload and operand helpers for the ID/EX issue stage.
package alu_issue_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 4;
    localparam int unsigned OPW = 4;

    // Register address that names no register; never matches for forwarding or hazards.
    localparam logic [AW-1:0] REG_NONE = '1;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        alu_op_e         op;
        logic [DW-1:0]   srca;
        logic [DW-1:0]   srcb;
        logic [AW-1:0]   rd_addr;
        logic            reg_write;
        logic            mem_read;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '{
        valid:     1'b0,
        op:        OP_ADD,
        srca:      '0,
        srcb:      '0,
        rd_addr:   REG_NONE,
        reg_write: 1'b0,
        mem_read:  1'b0
    };

    function automatic logic op_known(input logic [OPW-1:0] op);
        return op <= 4'(OP_SRA);
    endfunction

    function automatic logic op_is_shift(input logic [OPW-1:0] op);
        return (op == 4'(OP_SLL)) || (op == 4'(OP_SRL)) || (op == 4'(OP_SRA));
    endfunction

    // Immediate shift amount: low three bits, with 0 standing for a shift of 8.
    function automatic logic [DW-1:0] shamt_enc(input logic [DW-1:0] imm);
        logic [DW-1:0] amt;
        if (imm[2:0] == 3'd0) begin
            amt = DW'(8);
        end else begin
            amt = DW'(imm[2:0]);
        end
        return amt;
    endfunction

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Per-operand forwarding select: EX > MEM > WB > register file, ignoring the "none" address.
module alu_issue_fwd_mux
    import alu_issue_pkg::*;
(
    input  logic [AW-1:0] src_addr,
    input  logic [DW-1:0] rf_data,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data_c
);

    logic src_real;

    always_comb begin
        src_real = (src_addr != REG_NONE);
        data_c   = rf_data;
        if (src_real && ex_we && (ex_addr == src_addr)) begin
            data_c = ex_data;
        end else if (src_real && mem_we && (mem_addr == src_addr)) begin
            data_c = mem_data;
        end else if (src_real && wb_we && (wb_addr == src_addr)) begin
            data_c = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: forwards operands, lowers SUB and encodes shift amounts,
// inserts load-use bubbles and honours hold/flush before registering the ALU inputs.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_op,
    input  logic [AW-1:0]   id_rx_addr,
    input  logic [AW-1:0]   id_ry_addr,
    input  logic            id_rx_used,
    input  logic            id_ry_used,
    input  logic [DW-1:0]   id_rx_data,
    input  logic [DW-1:0]   id_ry_data,
    input  logic [DW-1:0]   id_imm,
    input  logic            id_b_sel,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic [DW-1:0]   alu_result,
    input  logic            mem_reg_write,
    input  logic [AW-1:0]   mem_rd_addr,
    input  logic [DW-1:0]   mem_data,
    input  logic            wb_reg_write,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            ex_hold,
    input  logic            flush,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [OPW-1:0]  ex_op,
    output logic [DW-1:0]   ex_srca,
    output logic [DW-1:0]   ex_srcb,
    output logic [AW-1:0]   ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read
);

    ex_reg_t       ex_q;
    ex_reg_t       ex_d;
    ex_reg_t       issue_c;
    logic          id_live_c;
    logic          rx_dep_c;
    logic          ry_dep_c;
    logic          load_use_c;
    logic          ex_fwd_we_c;
    logic [DW-1:0] rx_fwd_c;
    logic [DW-1:0] ry_fwd_c;
    logic [DW-1:0] b_raw_c;

    // A load in EX cannot forward; its value only becomes available from MEM.
    assign ex_fwd_we_c = ex_q.valid & ex_q.reg_write & ~ex_q.mem_read;

    alu_issue_fwd_mux u_fwd_a (
        .src_addr (id_rx_addr),
        .rf_data  (id_rx_data),
        .ex_we    (ex_fwd_we_c),
        .ex_addr  (ex_q.rd_addr),
        .ex_data  (alu_result),
        .mem_we   (mem_reg_write),
        .mem_addr (mem_rd_addr),
        .mem_data (mem_data),
        .wb_we    (wb_reg_write),
        .wb_addr  (wb_rd_addr),
        .wb_data  (wb_data),
        .data_c   (rx_fwd_c)
    );

    alu_issue_fwd_mux u_fwd_b (
        .src_addr (id_ry_addr),
        .rf_data  (id_ry_data),
        .ex_we    (ex_fwd_we_c),
        .ex_addr  (ex_q.rd_addr),
        .ex_data  (alu_result),
        .mem_we   (mem_reg_write),
        .mem_addr (mem_rd_addr),
        .mem_data (mem_data),
        .wb_we    (wb_reg_write),
        .wb_addr  (wb_rd_addr),
        .wb_data  (wb_data),
        .data_c   (ry_fwd_c)
    );

    // Hazard detection; an unknown op counts as no instruction and never stalls.
    always_comb begin
        id_live_c  = id_valid & op_known(id_op);
        rx_dep_c   = id_rx_used & (id_rx_addr != REG_NONE) & (id_rx_addr == ex_q.rd_addr);
        ry_dep_c   = id_ry_used & (id_ry_addr != REG_NONE) & (id_ry_addr == ex_q.rd_addr);
        load_use_c = id_live_c & ex_q.valid & ex_q.mem_read & ex_q.reg_write
                   & (rx_dep_c | ry_dep_c);
        stall_id   = ex_hold | load_use_c;
    end

    // Operand B selection and SUB lowering into the payload that would be issued.
    always_comb begin
        issue_c = EX_BUBBLE;
        if (id_b_sel) begin
            b_raw_c = op_is_shift(id_op) ? shamt_enc(id_imm) : id_imm;
        end else begin
            b_raw_c = ry_fwd_c;
        end
        issue_c.valid     = 1'b1;
        issue_c.srca      = rx_fwd_c;
        issue_c.rd_addr   = id_rd_addr;
        issue_c.reg_write = id_reg_write;
        issue_c.mem_read  = id_mem_read;
        if (id_op == 4'(OP_SUB)) begin
            issue_c.op   = OP_ADD;
            issue_c.srcb = ~b_raw_c + DW'(1);
        end else begin
            issue_c.op   = alu_op_e'(id_op);
            issue_c.srcb = b_raw_c;
        end
    end

    // Next EX contents: hold > flush > load-use > load.
    always_comb begin
        ex_d = ex_q;
        if (!ex_hold) begin
            if (flush || load_use_c || !id_live_c) begin
                ex_d = EX_BUBBLE;
            end else begin
                ex_d = issue_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_op        = ex_q.op;
    assign ex_srca      = ex_q.srca;
    assign ex_srcb      = ex_q.srcb;
    assign ex_rd_addr   = ex_q.rd_addr;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: table of single-instruction vectors plus hand-written
// forwarding, load-use, hold/flush and reset sequences.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [3:0]  id_rx_addr;
    logic [3:0]  id_ry_addr;
    logic        id_rx_used;
    logic        id_ry_used;
    logic [15:0] id_rx_data;
    logic [15:0] id_ry_data;
    logic [15:0] id_imm;
    logic        id_b_sel;
    logic [3:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic [15:0] alu_result;
    logic        mem_reg_write;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_data;
    logic        wb_reg_write;
    logic [3:0]  wb_rd_addr;
    logic [15:0] wb_data;
    logic        ex_hold;
    logic        flush;
    logic        stall_id;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [15:0] ex_srca;
    logic [15:0] ex_srcb;
    logic [3:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;

    int n_pass;
    int n_total;

    alu_issue dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_op         (id_op),
        .id_rx_addr    (id_rx_addr),
        .id_ry_addr    (id_ry_addr),
        .id_rx_used    (id_rx_used),
        .id_ry_used    (id_ry_used),
        .id_rx_data    (id_rx_data),
        .id_ry_data    (id_ry_data),
        .id_imm        (id_imm),
        .id_b_sel      (id_b_sel),
        .id_rd_addr    (id_rd_addr),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .alu_result    (alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .stall_id      (stall_id),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_srca       (ex_srca),
        .ex_srcb       (ex_srcb),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] rxd;
        logic [15:0] ryd;
        logic [15:0] imm;
        logic        bsel;
        logic [3:0]  e_op;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic        e_v;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op,
                          input logic [3:0] rx, input logic [3:0] ry,
                          input logic rxu, input logic ryu,
                          input logic [15:0] rxd, input logic [15:0] ryd,
                          input logic [15:0] imm, input logic bsel,
                          input logic [3:0] rd, input logic we, input logic mr);
        id_valid     = v;
        id_op        = op;
        id_rx_addr   = rx;
        id_ry_addr   = ry;
        id_rx_used   = rxu;
        id_ry_used   = ryu;
        id_rx_data   = rxd;
        id_ry_data   = ryd;
        id_imm       = imm;
        id_b_sel     = bsel;
        id_rd_addr   = rd;
        id_reg_write = we;
        id_mem_read  = mr;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 16'(ex_valid), 16'd0);
        chk({tag, "_op"},    16'(ex_op), 16'd0);
        chk({tag, "_srca"},  ex_srca, 16'd0);
        chk({tag, "_srcb"},  ex_srcb, 16'd0);
        chk({tag, "_rd"},    16'(ex_rd_addr), 16'hF);
        chk({tag, "_we"},    16'(ex_reg_write), 16'd0);
        chk({tag, "_mr"},    16'(ex_mem_read), 16'd0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b0;
        set_id(1'b0, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 4'd10, 1'b0, 1'b0);
        alu_result = 16'd0;
        mem_reg_write = 1'b0; mem_rd_addr = 4'd0; mem_data = 16'd0;
        wb_reg_write = 1'b0;  wb_rd_addr = 4'd0;  wb_data = 16'd0;
        ex_hold = 1'b0; flush = 1'b0;

        //            valid op     rxd       ryd       imm       bsel  e_op   e_a       e_b       e_v
        vecs[0]  = '{1'b1, 4'd0, 16'h0005, 16'h0007, 16'h0000, 1'b0, 4'd0, 16'h0005, 16'h0007, 1'b1};
        vecs[1]  = '{1'b1, 4'd1, 16'h0003, 16'h0005, 16'h0000, 1'b0, 4'd0, 16'h0003, 16'hFFFB, 1'b1};
        vecs[2]  = '{1'b1, 4'd2, 16'hF0F0, 16'h0000, 16'h00FF, 1'b1, 4'd2, 16'hF0F0, 16'h00FF, 1'b1};
        vecs[3]  = '{1'b1, 4'd3, 16'h1234, 16'h0F00, 16'h0000, 1'b0, 4'd3, 16'h1234, 16'h0F00, 1'b1};
        vecs[4]  = '{1'b1, 4'd4, 16'h0001, 16'h0000, 16'h0000, 1'b1, 4'd4, 16'h0001, 16'h0008, 1'b1};
        vecs[5]  = '{1'b1, 4'd6, 16'h8000, 16'h0000, 16'h0003, 1'b1, 4'd6, 16'h8000, 16'h0003, 1'b1};
        vecs[6]  = '{1'b1, 4'd5, 16'hFFFF, 16'h0000, 16'h00FD, 1'b1, 4'd5, 16'hFFFF, 16'h0005, 1'b1};
        vecs[7]  = '{1'b1, 4'd1, 16'h0010, 16'h0000, 16'h0001, 1'b1, 4'd0, 16'h0010, 16'hFFFF, 1'b1};
        vecs[8]  = '{1'b1, 4'd9, 16'h0005, 16'h0007, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 16'h0005, 16'h0007, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 4'd1, 16'h0004, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0004, 16'h0000, 1'b1};
        vecs[11] = '{1'b1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 4'd0, 16'hFFFF, 16'h0001, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_bubble("reset");
        @(negedge clk);
        rst = 1'b1;

        // Table: r1/r2 sources, rd=r10, nothing to forward
        for (int i = 0; i < 12; i++) begin
            set_id(vecs[i].valid, vecs[i].op, 4'd1, 4'd2, 1'b1, 1'b1, vecs[i].rxd, vecs[i].ryd,
                   vecs[i].imm, vecs[i].bsel, 4'd10, 1'b1, 1'b0);
            #1;
            chk($sformatf("v%0d_stall", i), 16'(stall_id), 16'd0);
            tick();
            chk($sformatf("v%0d_valid", i), 16'(ex_valid), 16'(vecs[i].e_v));
            chk($sformatf("v%0d_op", i), 16'(ex_op), 16'(vecs[i].e_op));
            chk($sformatf("v%0d_srca", i), ex_srca, vecs[i].e_a);
            chk($sformatf("v%0d_srcb", i), ex_srcb, vecs[i].e_b);
            chk($sformatf("v%0d_rd", i), 16'(ex_rd_addr), vecs[i].e_v ? 16'd10 : 16'hF);
            chk($sformatf("v%0d_we", i), 16'(ex_reg_write), 16'(vecs[i].e_v));
        end

        // EX forwarding: ADD r3 then OR reading r3
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        tick();
        alu_result = 16'h00AA;
        set_id(1'b1, 4'd3, 4'd3, 4'd4, 1'b1, 1'b1, 16'h1111, 16'h0001, 16'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        chk("fwd_ex_srca", ex_srca, 16'h00AA);
        chk("fwd_ex_srcb", ex_srcb, 16'h0001);
        chk("fwd_ex_op", 16'(ex_op), 16'd3);

        // Priority EX > MEM > WB > register file, all on r5
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        alu_result = 16'h0AAA;
        mem_reg_write = 1'b1; mem_rd_addr = 4'd5; mem_data = 16'h0BBB;
        wb_reg_write = 1'b1;  wb_rd_addr = 4'd5;  wb_data = 16'h0CCC;
        set_id(1'b1, 4'd0, 4'd5, 4'd5, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        tick();
        chk("prio_ex_a", ex_srca, 16'h0AAA);
        chk("prio_ex_b", ex_srcb, 16'h0AAA);
        tick();
        chk("prio_mem_a", ex_srca, 16'h0BBB);
        chk("prio_mem_b", ex_srcb, 16'h0BBB);
        mem_reg_write = 1'b0;
        tick();
        chk("prio_wb_a", ex_srca, 16'h0CCC);
        wb_reg_write = 1'b0;
        tick();
        chk("prio_rf_a", ex_srca, 16'h1111);
        chk("prio_rf_b", ex_srcb, 16'h2222);

        // The "none" address never forwards, even when every stage writes it
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 4'hF, 1'b1, 1'b0);
        tick();
        mem_reg_write = 1'b1; mem_rd_addr = 4'hF; mem_data = 16'hBAD0;
        wb_reg_write = 1'b1;  wb_rd_addr = 4'hF;  wb_data = 16'hBAD1;
        set_id(1'b1, 4'd0, 4'hF, 4'hF, 1'b1, 1'b1, 16'h3333, 16'h4444, 16'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        tick();
        chk("none_a", ex_srca, 16'h3333);
        chk("none_b", ex_srcb, 16'h4444);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Load-use: load r4, then ADD reading r4
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 4'd4, 1'b1, 1'b1);
        tick();
        chk("ld_mr", 16'(ex_mem_read), 16'd1);
        set_id(1'b1, 4'd0, 4'd4, 4'd2, 1'b0, 1'b1, 16'hDEAD, 16'h0002, 16'd0, 1'b0, 4'd8, 1'b1, 1'b0);
        #1;
        chk("lu_unused_src_stall", 16'(stall_id), 16'd0);
        id_rx_used = 1'b1;
        #1;
        chk("lu_stall_on", 16'(stall_id), 16'd1);
        tick();
        chk("lu_bubble_valid", 16'(ex_valid), 16'd0);
        chk("lu_bubble_we", 16'(ex_reg_write), 16'd0);
        mem_reg_write = 1'b1; mem_rd_addr = 4'd4; mem_data = 16'h4444;
        #1;
        chk("lu_stall_off", 16'(stall_id), 16'd0);
        tick();
        chk("lu_issue_valid", 16'(ex_valid), 16'd1);
        chk("lu_mem_fwd_a", ex_srca, 16'h4444);
        chk("lu_srcb", ex_srcb, 16'h0002);
        mem_reg_write = 1'b0;

        // Flush during load-use: bubble loaded, stall still follows load-use
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 4'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd0, 4'd2, 4'd4, 1'b1, 1'b1, 16'd1, 16'd2, 16'd0, 1'b0, 4'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_lu_stall", 16'(stall_id), 16'd1);
        tick();
        chk("fl_lu_valid", 16'(ex_valid), 16'd0);
        flush = 1'b0;

        // Hold with flush for 3 cycles: EX frozen; release with flush loads a bubble
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'h0005, 16'h0007, 16'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        tick();
        chk("hold_pre_a", ex_srca, 16'h0005);
        ex_hold = 1'b1;
        flush = 1'b1;
        set_id(1'b1, 4'd1, 4'd1, 4'd2, 1'b1, 1'b1, 16'h0099, 16'h0001, 16'd0, 1'b0, 4'd11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_stall", i), 16'(stall_id), 16'd1);
            chk($sformatf("hold%0d_valid", i), 16'(ex_valid), 16'd1);
            chk($sformatf("hold%0d_a", i), ex_srca, 16'h0005);
            chk($sformatf("hold%0d_b", i), ex_srcb, 16'h0007);
            chk($sformatf("hold%0d_rd", i), 16'(ex_rd_addr), 16'd9);
        end
        ex_hold = 1'b0;
        tick();
        chk_bubble("rel_flush");
        flush = 1'b0;

        // Async reset in the middle of a hold
        set_id(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 16'h0005, 16'h0007, 16'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        tick();
        chk("rst_pre_valid", 16'(ex_valid), 16'd1);
        ex_hold = 1'b1;
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk_bubble("rst_mid_hold");
        @(negedge clk);
        rst = 1'b1;
        ex_hold = 1'b0;
        id_valid = 1'b0;
        tick();
        chk("post_rst_valid", 16'(ex_valid), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
